tt_sweep_capture: RTL and testbench

Exhaustive-stimulus stage that sits directly upstream and downstream of a 4-input single-output AIG cone. It drives all 16 input minterms onto x[3:0] and samples the cone's y0 into a 16-bit truth table. It then compares the captured table against an expected table and presents the verdict over a valid/ready handshake. It is the on-chip checker used to confirm each NPN-class exact netlist.

---
 rtl/tt_sweep_pkg.sv | 24 ++
 rtl/tt_sweep_capture_compare.sv | 29 ++
 rtl/tt_sweep_capture.sv | 146 ++++++++++++++
 tb/tb_tt_sweep_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Cone width is fixed at four inputs, giving a 16-entry table.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        RESULT
    } state_e;

    localparam int TT_W  = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    function automatic logic [CNT_W-1:0] popcount16(input logic [TT_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < TT_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_compare.sv
// Combinational verdict: compares a captured truth table with the golden one.
// Produces match flag, mismatch popcount and lowest differing minterm.
module tt_compare
    import tt_sweep_pkg::*;
(
    input  logic [TT_W-1:0]  cap,
    input  logic [TT_W-1:0]  expected,
    output logic             match,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [IDX_W-1:0] first_mismatch
);

    logic [TT_W-1:0] diff;

    assign diff         = cap ^ expected;
    assign match        = (diff == '0);
    assign mismatch_cnt = popcount16(diff);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        first_mismatch = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                first_mismatch = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives all minterms into a 4-input cone, captures its truth table,
// and reports the verdict against a golden table over valid/ready.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int NUM_INPUTS    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TT_W-1:0]       expected_tt,
    output logic [NUM_INPUTS-1:0] x,
    input  logic                  y_in,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [TT_W-1:0]       tt_out,
    output logic                  match,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [IDX_W-1:0]      first_mismatch
);

    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TT_W-1:0]  cap_q, cap_d;
    logic [TT_W-1:0]  exp_q, exp_d;
    logic [TT_W-1:0]  tt_q, tt_d;
    logic             valid_q, valid_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [IDX_W-1:0] fm_q, fm_d;

    logic [TT_W-1:0]  cap_s;
    logic             cmp_match;
    logic [CNT_W-1:0] cmp_cnt;
    logic [IDX_W-1:0] cmp_fm;

    // Capture register with the current sample merged in; on the last
    // minterm this is the complete table the verdict is computed from.
    always_comb begin
        cap_s        = cap_q;
        cap_s[idx_q] = y_in;
    end

    tt_compare u_cmp (
        .cap            (cap_s),
        .expected       (exp_q),
        .match          (cmp_match),
        .mismatch_cnt   (cmp_cnt),
        .first_mismatch (cmp_fm)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        valid_d = valid_q;
        match_d = match_q;
        mcnt_d  = mcnt_q;
        fm_d    = fm_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = expected_tt;
                    idx_d   = '0;
                    cnt_d   = SETTLE;
                    cap_d   = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cap_d = cap_s;
                    if (idx_q != IDX_W'(TT_W - 1)) begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = SETTLE;
                    end else begin
                        idx_d   = '0;
                        tt_d    = cap_s;
                        match_d = cmp_match;
                        mcnt_d  = cmp_cnt;
                        fm_d    = cmp_fm;
                        valid_d = 1'b1;
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            mcnt_q  <= '0;
            fm_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            valid_q <= valid_d;
            match_q <= match_d;
            mcnt_q  <= mcnt_d;
            fm_q    <= fm_d;
        end
    end

    assign busy           = (state_q == SWEEP);
    assign x              = busy ? NUM_INPUTS'(idx_q) : '0;
    assign result_valid   = valid_q;
    assign tt_out         = tt_q;
    assign match          = match_q;
    assign mismatch_cnt   = mcnt_q;
    assign first_mismatch = fm_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture with a behavioural cone and a
// scoreboard of expected verdicts; a second instance uses zero settle.
module tb_tt_sweep_capture;

    typedef struct {
        logic [15:0] tt;
        logic        m;
        logic [4:0]  cnt;
        logic [3:0]  fm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
    logic [15:0] exp1 = '0;
    logic [3:0]  x1;
    logic        y1, busy1, valid1, match1;
    logic [15:0] tt1;
    logic [4:0]  cnt1;
    logic [3:0]  fm1;
    int          cone1 = 0;

    logic        start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b1;
    logic [15:0] exp0 = 16'hFF00;
    logic [3:0]  x0;
    logic        y0, busy0, valid0, match0;
    logic [15:0] tt0;
    logic [4:0]  cnt0;
    logic [3:0]  fm0;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic cone_f(input int mode, input logic [3:0] xv);
        case (mode)
            0:       return xv[0] & xv[1];
            1:       return 1'b1;
            2:       return xv[3];
            default: return 1'b0;
        endcase
    endfunction

    assign y1 = cone_f(cone1, x1);
    assign y0 = cone_f(2, x0);

    tt_sweep_capture #(.NUM_INPUTS(4), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .expected_tt(exp1), .x(x1), .y_in(y1), .busy(busy1),
        .result_valid(valid1), .result_ready(ready1), .tt_out(tt1),
        .match(match1), .mismatch_cnt(cnt1), .first_mismatch(fm1)
    );

    tt_sweep_capture #(.NUM_INPUTS(4), .SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .expected_tt(exp0), .x(x0), .y_in(y0), .busy(busy0),
        .result_valid(valid0), .result_ready(ready0), .tt_out(tt0),
        .match(match0), .mismatch_cnt(cnt0), .first_mismatch(fm0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int mode, input logic [15:0] g);
        exp_t e;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) e.tt[i] = cone_f(mode, 4'(i));
        d = e.tt ^ g;
        e.m = (d == 16'h0);
        e.cnt = '0;
        e.fm = '0;
        for (int i = 0; i < 16; i++) e.cnt = e.cnt + {4'b0, d[i]};
        for (int i = 15; i >= 0; i--) if (d[i]) e.fm = 4'(i);
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x"}, x1, 0);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_valid"}, valid1, 0);
        chk({tag, "_tt"}, tt1, 0);
        chk({tag, "_match"}, match1, 0);
        chk({tag, "_cnt"}, cnt1, 0);
        chk({tag, "_fm"}, fm1, 0);
    endtask

    task automatic sweep(input int mode, input logic [15:0] g, input int hold);
        exp_t e;
        int k;
        cone1  = mode;
        exp1   = g;
        ready1 = (hold == 0);
        sb.push_back(model(mode, g));
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        exp1 = ~g;
        k = 0;
        while (!valid1 && k < 100) begin
            chk("sweep_x", x1, k / 2);
            chk("sweep_busy", busy1, 1);
            @(negedge clk);
            k++;
        end
        chk("latency", k, 32);
        if (valid1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("tt_out", tt1, e.tt);
            chk("match", match1, e.m);
            chk("mcnt", cnt1, e.cnt);
            chk("first", fm1, e.fm);
            chk("res_x", x1, 0);
            chk("res_busy", busy1, 0);
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", valid1, 1);
                chk("hold_tt", tt1, e.tt);
                chk("hold_cnt", cnt1, e.cnt);
                chk("hold_fm", fm1, e.fm);
                chk("hold_match", match1, e.m);
                start1 = 1'b1;
            end
            ready1 = 1'b1;
        end else begin
            chk("result_timeout", valid1, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clk);
        start1 = 1'b0;
        chk("post_valid", valid1, 0);
        @(negedge clk);
        chk("post_busy", busy1, 0);
    endtask

    initial begin
        int k;
        logic seen;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        sweep(0, 16'h8888, 0);
        sweep(0, 16'h8889, 0);
        sweep(0, 16'h0000, 0);
        sweep(1, 16'h0000, 5);

        cone1  = 0;
        ready1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        while (x1 != 4'd7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach7", x1, 7);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_x", x1, 0);
        chk("abort_valid", valid1, 0);
        chk("abort_tt", tt1, 16'hFFFF);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= valid1;
        end
        chk("abort_noresult", seen, 0);
        sweep(0, 16'h8888, 0);

        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        while (x1 != 4'd9 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach9", x1, 9);
        #2 rst = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sweep(2, 16'hFF00, 0);
        sweep(0, 16'h0000, 0);

        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while (!valid0 && k < 100) begin
            chk("s0_x", x0, k);
            @(negedge clk);
            k++;
        end
        chk("s0_latency", k, 16);
        chk("s0_tt", tt0, 16'hFF00);
        chk("s0_match", match0, 1);
        chk("s0_cnt", cnt0, 0);
        chk("s0_fm", fm0, 0);
        @(negedge clk);
        chk("s0_post_valid", valid0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
